// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave arbiter for the SRAM-like req/addr_ok/data_ok bus.
// A small ID FIFO sends each data_ok back to the master that issued the request, in issue order.
module sram_like_arbiter #(
  parameter int NUM_M   = 2,
  parameter int DEPTH   = 4,
  parameter int RR_MODE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_M-1:0]         m_req,
  input  logic [NUM_M-1:0]         m_wr,
  input  logic [2*NUM_M-1:0]       m_size,
  input  logic [4*NUM_M-1:0]       m_wstrb,
  input  logic [32*NUM_M-1:0]      m_addr,
  input  logic [32*NUM_M-1:0]      m_wdata,
  output logic [NUM_M-1:0]         m_addr_ok,
  output logic [NUM_M-1:0]         m_data_ok,
  output logic [31:0]              m_rdata,
  output logic                     s_req,
  output logic                     s_wr,
  output logic [1:0]               s_size,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic                     s_addr_ok,
  input  logic                     s_data_ok,
  input  logic [31:0]              s_rdata,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexp
);

  localparam int IDW = $clog2(NUM_M);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  // Handshake: a request is accepted in the cycle where req and addr_ok are both high;
  // every accepted request is answered by exactly one data_ok later, in issue order.

  logic [IDW-1:0] r_fifo [DEPTH];
  logic [PW-1:0]  r_wptr;
  logic [PW-1:0]  r_rptr;
  logic [CW-1:0]  r_count;
  logic           r_lock_vld;
  logic [IDW-1:0] r_lock_id;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_err;

  logic [IDW-1:0] w_g;
  logic           w_eligible;
  logic           w_push;
  logic           w_pop;
  logic [IDW-1:0] w_head;

  always_comb begin : grant_sel
    logic found;
    int   idx;
    found = 1'b0;
    idx   = 0;
    w_g   = '0;
    if (r_lock_vld) begin
      w_g = r_lock_id;
    end else if (RR_MODE != 0) begin
      for (int k = 0; k < NUM_M; k++) begin
        idx = (int'(r_rr_ptr) + k) % NUM_M;
        if (!found && m_req[idx]) begin
          found = 1'b1;
          w_g   = IDW'(idx);
        end
      end
    end else begin
      for (int i = 0; i < NUM_M; i++) begin
        if (m_req[i]) w_g = IDW'(i);
      end
    end
  end

  // A full FIFO may still accept when a return frees the head slot in the same cycle.
  assign w_eligible = (r_count < CW'(DEPTH)) || s_data_ok;
  assign s_req      = ~reset & w_eligible & m_req[w_g];
  assign w_push     = s_req & s_addr_ok;
  assign w_pop      = s_data_ok & (r_count != '0);
  assign w_head     = r_fifo[r_rptr];

  always_comb begin
    s_wr      = 1'b0;
    s_size    = '0;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_g == IDW'(i)) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_wstrb = m_wstrb[4*i +: 4];
        s_addr  = m_addr[32*i +: 32];
        s_wdata = m_wdata[32*i +: 32];
      end
    end
    m_addr_ok[w_g] = w_push;
    if (w_pop) m_data_ok[w_head] = 1'b1;
  end

  assign m_rdata     = s_rdata;
  assign outstanding = r_count;
  assign err_unexp   = r_err;

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_g;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= '0;
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Lock holds a stalled grant; it drops on accept or when the master withdraws.
      r_lock_vld <= s_req & ~s_addr_ok;
      if (s_req & ~s_addr_ok) r_lock_id <= w_g;
      if ((RR_MODE != 0) && w_push)
        r_rr_ptr <= (w_g == IDW'(NUM_M - 1)) ? '0 : w_g + IDW'(1);
      if (s_data_ok && (r_count == '0)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a fixed-priority 2-master instance and a round-robin 3-master
// instance; accept and return events are checked against queued expectations by negedge monitors.
module tb_sram_like_arbiter;

  localparam int W = 36;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [W-1:0] a_acc_q[$];
  logic [W-1:0] a_ret_q[$];
  logic [W-1:0] b_acc_q[$];

  // instance A: NUM_M=2, DEPTH=4, fixed priority
  logic [1:0]  a_m_req, a_m_wr, a_m_addr_ok, a_m_data_ok;
  logic [3:0]  a_m_size;
  logic [7:0]  a_m_wstrb;
  logic [63:0] a_m_addr, a_m_wdata;
  logic [31:0] a_m_rdata, a_s_addr, a_s_wdata, a_s_rdata;
  logic        a_s_req, a_s_wr, a_s_addr_ok, a_s_data_ok, a_err;
  logic [1:0]  a_s_size;
  logic [3:0]  a_s_wstrb;
  logic [2:0]  a_outstanding;

  // instance B: NUM_M=3, DEPTH=8, round-robin
  logic [2:0]  b_m_req, b_m_wr, b_m_addr_ok, b_m_data_ok;
  logic [5:0]  b_m_size;
  logic [11:0] b_m_wstrb;
  logic [95:0] b_m_addr, b_m_wdata;
  logic [31:0] b_m_rdata, b_s_addr, b_s_wdata, b_s_rdata;
  logic        b_s_req, b_s_wr, b_s_addr_ok, b_s_data_ok, b_err;
  logic [1:0]  b_s_size;
  logic [3:0]  b_s_wstrb;
  logic [3:0]  b_outstanding;

  sram_like_arbiter #(.NUM_M(2), .DEPTH(4), .RR_MODE(0)) u_dut_a (
    .clk(clk), .reset(reset),
    .m_req(a_m_req), .m_wr(a_m_wr), .m_size(a_m_size), .m_wstrb(a_m_wstrb),
    .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_addr_ok(a_m_addr_ok), .m_data_ok(a_m_data_ok), .m_rdata(a_m_rdata),
    .s_req(a_s_req), .s_wr(a_s_wr), .s_size(a_s_size), .s_wstrb(a_s_wstrb),
    .s_addr(a_s_addr), .s_wdata(a_s_wdata),
    .s_addr_ok(a_s_addr_ok), .s_data_ok(a_s_data_ok), .s_rdata(a_s_rdata),
    .outstanding(a_outstanding), .err_unexp(a_err)
  );

  sram_like_arbiter #(.NUM_M(3), .DEPTH(8), .RR_MODE(1)) u_dut_b (
    .clk(clk), .reset(reset),
    .m_req(b_m_req), .m_wr(b_m_wr), .m_size(b_m_size), .m_wstrb(b_m_wstrb),
    .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_addr_ok(b_m_addr_ok), .m_data_ok(b_m_data_ok), .m_rdata(b_m_rdata),
    .s_req(b_s_req), .s_wr(b_s_wr), .s_size(b_s_size), .s_wstrb(b_s_wstrb),
    .s_addr(b_s_addr), .s_wdata(b_s_wdata),
    .s_addr_ok(b_s_addr_ok), .s_data_ok(b_s_data_ok), .s_rdata(b_s_rdata),
    .outstanding(b_outstanding), .err_unexp(b_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic [1:0] req, input logic [31:0] ad0, input logic [31:0] ad1,
                         input logic aok, input logic dok, input logic [31:0] rd);
    a_m_req     = req;
    a_m_addr    = {ad1, ad0};
    a_s_addr_ok = aok;
    a_s_data_ok = dok;
    a_s_rdata   = rd;
  endtask

  task automatic push_acc_a(input int id, input logic [31:0] ad);
    a_acc_q.push_back({4'(id), ad});
  endtask

  task automatic push_ret_a(input int id, input logic [31:0] rd);
    a_ret_q.push_back({4'(id), rd});
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [1:0]   oh;
    if (!reset) begin
      if (a_s_req && a_s_addr_ok) begin
        if (a_acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_accept unexpected addr=%0h", a_s_addr);
        end else begin
          e = a_acc_q.pop_front();
          oh = '0; oh[e[32]] = 1'b1;
          chk("a_accept_addr", 64'(a_s_addr), 64'(e[31:0]));
          chk("a_accept_addr_ok", 64'(a_m_addr_ok), 64'(oh));
        end
      end
      if (a_m_data_ok != '0) begin
        if (a_ret_q.size() == 0) begin
          total++; bad++;
          $display("FAIL a_return unexpected data_ok=%0b", a_m_data_ok);
        end else begin
          e = a_ret_q.pop_front();
          oh = '0; oh[e[32]] = 1'b1;
          chk("a_return_data_ok", 64'(a_m_data_ok), 64'(oh));
          chk("a_return_rdata", 64'(a_m_rdata), 64'(e[31:0]));
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [2:0]   oh;
    if (!reset) begin
      if (b_s_req && b_s_addr_ok) begin
        if (b_acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL b_accept unexpected addr=%0h", b_s_addr);
        end else begin
          e = b_acc_q.pop_front();
          oh = '0; oh[e[33:32]] = 1'b1;
          chk("b_rr_grant_addr", 64'(b_s_addr), 64'(e[31:0]));
          chk("b_rr_grant_addr_ok", 64'(b_m_addr_ok), 64'(oh));
        end
      end
      if (b_m_data_ok != '0) begin
        total++; bad++;
        $display("FAIL b_return unexpected data_ok=%0b", b_m_data_ok);
      end
    end
  end

  // stimulus
  initial begin
    int rr_exp [6];
    rr_exp = '{0, 1, 2, 0, 1, 2};
    total = 0;
    bad   = 0;
    reset = 1'b1;
    a_drive(2'b11, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    a_m_wr = 2'b00; a_m_size = 4'b1010; a_m_wstrb = 8'hFF; a_m_wdata = '0;
    b_m_req = '0; b_m_wr = '0; b_m_size = '0; b_m_wstrb = '0; b_m_addr = '0; b_m_wdata = '0;
    b_s_addr_ok = 1'b0; b_s_data_ok = 1'b0; b_s_rdata = '0;
    #2;
    chk("reset_outstanding", 64'(a_outstanding), 64'd0);
    chk("reset_s_req", 64'(a_s_req), 64'd0);
    chk("reset_m_addr_ok", 64'(a_m_addr_ok), 64'd0);
    chk("reset_m_data_ok", 64'(a_m_data_ok), 64'd0);
    chk("reset_err", 64'(a_err), 64'd0);
    next_cyc();
    next_cyc();
    reset = 1'b0;

    // single-master read
    a_drive(2'b01, 32'hBFC00000, 32'h0, 1'b1, 1'b0, 32'h0);
    push_acc_a(0, 32'hBFC00000);
    @(negedge clk); chk("t1_s_req", 64'(a_s_req), 64'd1);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t1_outstanding_1", 64'(a_outstanding), 64'd1);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'h24010001);
    push_ret_a(0, 32'h24010001);
    @(negedge clk); chk("t1_outstanding_still_1", 64'(a_outstanding), 64'd1);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t1_outstanding_0", 64'(a_outstanding), 64'd0);
    next_cyc();

    // fixed priority and return order
    a_m_wr = 2'b10;
    a_drive(2'b11, 32'h1000, 32'h2000, 1'b1, 1'b0, 32'h0);
    push_acc_a(1, 32'h2000);
    @(negedge clk); chk("t2_s_wr_from_m1", 64'(a_s_wr), 64'd1);
    next_cyc();
    a_drive(2'b01, 32'h1000, 32'h2000, 1'b1, 1'b0, 32'h0);
    push_acc_a(0, 32'h1000);
    @(negedge clk); chk("t2_s_wr_from_m0", 64'(a_s_wr), 64'd0);
    next_cyc();
    a_m_wr = 2'b00;
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t2_outstanding_2", 64'(a_outstanding), 64'd2);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hAAAA);
    push_ret_a(1, 32'hAAAA);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBBBB);
    push_ret_a(0, 32'hBBBB);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t2_outstanding_0", 64'(a_outstanding), 64'd0);
    next_cyc();

    // grant lock while addr_ok is held low
    a_drive(2'b01, 32'h3000, 32'h4000, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t4_lock_addr_c0", 64'(a_s_addr), 64'h3000);
    next_cyc();
    for (int c = 1; c <= 2; c++) begin
      a_drive(2'b11, 32'h3000, 32'h4000, 1'b0, 1'b0, 32'h0);
      @(negedge clk);
      chk("t4_lock_addr_held", 64'(a_s_addr), 64'h3000);
      chk("t4_lock_addr_ok_low", 64'(a_m_addr_ok), 64'd0);
      next_cyc();
    end
    a_drive(2'b11, 32'h3000, 32'h4000, 1'b1, 1'b0, 32'h0);
    push_acc_a(0, 32'h3000);
    @(negedge clk); chk("t4_lock_addr_c3", 64'(a_s_addr), 64'h3000);
    next_cyc();
    a_drive(2'b10, 32'h3000, 32'h4000, 1'b1, 1'b0, 32'h0);
    push_acc_a(1, 32'h4000);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t4_outstanding_2", 64'(a_outstanding), 64'd2);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC0);
    push_ret_a(0, 32'hC0);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hC1);
    push_ret_a(1, 32'hC1);
    next_cyc();

    // full FIFO, then accept-with-return at full
    for (int k = 0; k < 4; k++) begin
      a_drive(2'b01, 32'h5000 + 32'(4 * k), 32'h0, 1'b1, 1'b0, 32'h0);
      push_acc_a(0, 32'h5000 + 32'(4 * k));
      next_cyc();
    end
    a_drive(2'b01, 32'h6000, 32'h0, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    chk("t5_full_s_req", 64'(a_s_req), 64'd0);
    chk("t5_full_outstanding", 64'(a_outstanding), 64'd4);
    next_cyc();
    a_drive(2'b01, 32'h6000, 32'h0, 1'b1, 1'b1, 32'hD0);
    push_ret_a(0, 32'hD0);
    push_acc_a(0, 32'h6000);
    @(negedge clk); chk("t5_full_pop_s_req", 64'(a_s_req), 64'd1);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t5_outstanding_stays_4", 64'(a_outstanding), 64'd4);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hD1);
    push_ret_a(0, 32'hD1);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hD2);
    push_ret_a(0, 32'hD2);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk); chk("t6_outstanding_2", 64'(a_outstanding), 64'd2);
    next_cyc();

    // async reset with 2 outstanding, then an unexpected return
    reset = 1'b1;
    #1;
    chk("t6_reset_outstanding", 64'(a_outstanding), 64'd0);
    next_cyc();
    reset = 1'b0;
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b1, 32'hEE);
    @(negedge clk);
    chk("t6_err_before", 64'(a_err), 64'd0);
    chk("t6_unexp_data_ok", 64'(a_m_data_ok), 64'd0);
    next_cyc();
    a_drive(2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t6_err_set", 64'(a_err), 64'd1);
    chk("t6_outstanding_0", 64'(a_outstanding), 64'd0);
    next_cyc();
    @(negedge clk); chk("t6_err_sticky", 64'(a_err), 64'd1);
    next_cyc();

    // round-robin on instance B
    b_m_req     = 3'b111;
    b_m_addr    = {32'h300, 32'h200, 32'h100};
    b_s_addr_ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b_acc_q.push_back({4'(rr_exp[k]), 32'h100 * 32'(rr_exp[k] + 1)});
      next_cyc();
    end
    b_m_req     = '0;
    b_s_addr_ok = 1'b0;
    @(negedge clk);
    chk("b_outstanding_6", 64'(b_outstanding), 64'd6);
    chk("a_acc_q_drained", 64'(a_acc_q.size()), 64'd0);
    chk("a_ret_q_drained", 64'(a_ret_q.size()), 64'd0);
    chk("b_acc_q_drained", 64'(b_acc_q.size()), 64'd0);
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
